// File: rtl/tile_match_engine.sv
// Memory-match engine: selects two tiles, compares their symbols, latches matched pairs and counts moves.
// Optional MISS_LIMIT_EN adds a miss counter, a LOST state and the game_over output.
module tile_match_engine #(
  parameter int N_TILES     = 16,
  parameter int SYM_W       = 3,
  parameter int IDX_W       = 4,
  parameter int SHOW_CYCLES = 50000000,
  parameter int MOVE_W      = 8,
  parameter int MAX_MISSES  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_TILES-1:0]       switches,
  input  logic [N_TILES*SYM_W-1:0] tiles,
  output logic [N_TILES-1:0]       leds,
  output logic [N_TILES-1:0]       revealed,
  output logic [IDX_W-1:0]         first_idx,
  output logic [IDX_W-1:0]         second_idx,
  output logic [MOVE_W-1:0]        moves,
  output logic                     match_pulse,
  output logic                     miss_pulse,
  output logic                     busy,
  output logic                     win
`ifdef MISS_LIMIT_EN
  ,
  output logic                     game_over
`endif
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);

  if (N_TILES < 2 || N_TILES > 64 || (N_TILES % 2) != 0 || IDX_W < $clog2(N_TILES) ||
      SHOW_CYCLES < 1 || MAX_MISSES < 1) begin : g_bad_params
    $error("tile_match_engine: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, ONE, CMP, SHOW, WON, LOST} state_t;

  state_t               state, state_d;
  logic [N_TILES-1:0]   sw_q;
  logic [N_TILES-1:0]   sw_rise, sw_fall, valid;
  logic [N_TILES-1:0]   leds_d, revealed_d;
  logic [IDX_W-1:0]     first_d, second_d, pick_idx;
  logic                 first_vld, first_vld_d, second_vld, second_vld_d, pick_vld;
  logic [MOVE_W-1:0]    moves_d;
  logic                 match_d, miss_d;
  logic [CNT_W-1:0]     show_cnt, show_cnt_d;
  logic [SYM_W-1:0]     sym_a, sym_b;
  logic                 cancel;

`ifdef MISS_LIMIT_EN
  localparam int MISS_W = $clog2(MAX_MISSES + 1);
  logic [MISS_W-1:0]    miss_cnt, miss_cnt_d;
`endif

  function automatic logic [N_TILES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    for (int k = 0; k < N_TILES; k++) onehot[k] = (idx == IDX_W'(k));
  endfunction

  // The index registers read all-ones when empty, which can alias tile N_TILES-1,
  // so the *_vld flags decide whether an index really names a selected tile.
  assign sw_rise = switches & ~sw_q;
  assign sw_fall = ~switches & sw_q;
  assign valid   = sw_rise & ~leds & ~(first_vld ? onehot(first_idx) : '0);
  assign cancel  = (state == ONE) && (|(sw_fall & onehot(first_idx)));

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_TILES - 1; k >= 0; k--) begin
      if (valid[k]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    sym_a = '0;
    sym_b = '0;
    for (int k = 0; k < N_TILES; k++) begin
      if (first_idx == IDX_W'(k))  sym_a = tiles[k*SYM_W +: SYM_W];
      if (second_idx == IDX_W'(k)) sym_b = tiles[k*SYM_W +: SYM_W];
    end
  end

  always_comb begin
    state_d      = state;
    first_d      = first_idx;
    first_vld_d  = first_vld;
    second_d     = second_idx;
    second_vld_d = second_vld;
    leds_d       = leds;
    moves_d      = moves;
    match_d      = 1'b0;
    miss_d       = 1'b0;
    show_cnt_d   = show_cnt;
`ifdef MISS_LIMIT_EN
    miss_cnt_d   = miss_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          first_d     = pick_idx;
          first_vld_d = 1'b1;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (cancel) begin
          first_d     = '1;
          first_vld_d = 1'b0;
          state_d     = IDLE;
        end else if (pick_vld) begin
          second_d     = pick_idx;
          second_vld_d = 1'b1;
          state_d      = CMP;
        end
      end
      CMP: begin
        if (moves != '1) moves_d = moves + MOVE_W'(1);
        if (sym_a == sym_b) begin
          leds_d       = leds | onehot(first_idx) | onehot(second_idx);
          match_d      = 1'b1;
          first_d      = '1;
          second_d     = '1;
          first_vld_d  = 1'b0;
          second_vld_d = 1'b0;
          state_d      = (leds_d == '1) ? WON : IDLE;
        end else begin
          miss_d     = 1'b1;
          show_cnt_d = SHOW_LOAD;
          state_d    = SHOW;
`ifdef MISS_LIMIT_EN
          if (miss_cnt != MISS_W'(MAX_MISSES)) miss_cnt_d = miss_cnt + MISS_W'(1);
`endif
        end
      end
      SHOW: begin
        if (show_cnt == '0) begin
          first_d      = '1;
          second_d     = '1;
          first_vld_d  = 1'b0;
          second_vld_d = 1'b0;
          state_d      = IDLE;
`ifdef MISS_LIMIT_EN
          if (miss_cnt == MISS_W'(MAX_MISSES)) state_d = LOST;
`endif
        end else begin
          show_cnt_d = show_cnt - CNT_W'(1);
        end
      end
      WON, LOST: ;
      default: state_d = IDLE;
    endcase

    revealed_d = leds_d | (first_vld_d ? onehot(first_d) : '0) |
                 (second_vld_d ? onehot(second_d) : '0);
`ifdef MISS_LIMIT_EN
    if (state_d == LOST) revealed_d = '1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sw_q        <= '0;
      leds        <= '0;
      revealed    <= '0;
      first_idx   <= '1;
      second_idx  <= '1;
      first_vld   <= 1'b0;
      second_vld  <= 1'b0;
      moves       <= '0;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      show_cnt    <= '0;
`ifdef MISS_LIMIT_EN
      miss_cnt    <= '0;
`endif
    end else begin
      state       <= state_d;
      sw_q        <= switches;
      leds        <= leds_d;
      revealed    <= revealed_d;
      first_idx   <= first_d;
      second_idx  <= second_d;
      first_vld   <= first_vld_d;
      second_vld  <= second_vld_d;
      moves       <= moves_d;
      match_pulse <= match_d;
      miss_pulse  <= miss_d;
      show_cnt    <= show_cnt_d;
`ifdef MISS_LIMIT_EN
      miss_cnt    <= miss_cnt_d;
`endif
    end
  end

  assign busy = (state == CMP) || (state == SHOW);
  assign win  = (state == WON);
`ifdef MISS_LIMIT_EN
  assign game_over = (state == LOST);
`endif

endmodule
